// File: rtl/logger_pkg.sv
// Shared types and default widths for the logger event arbiter.
package logger_pkg;

  localparam int TS_W_DEF = 64;
  localparam int ID_W_DEF = 16;

  // One timestamped event as produced by a per-port timestamper.
  typedef struct packed {
    logic [ID_W_DEF-1:0] id;
    logic [TS_W_DEF-1:0] start;
    logic [TS_W_DEF-1:0] end_ts;
    logic [TS_W_DEF-1:0] delta;
  } ev_t;

  // Output register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/logger_rr_pick.sv
// Combinational round-robin picker: rotate so ptr sits at bit 0,
// priority-encode the lowest request, then rotate the index back.
module logger_rr_pick #(
  parameter int  NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt_onehot,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_any
);

  typedef logic [CH_W:0]   sum_t;
  typedef logic [CH_W-1:0] ch_t;

  // (a + b) mod NUM_CH for a < NUM_CH and b < NUM_CH; works for any NUM_CH.
  function automatic ch_t wrap_add(input ch_t a, input int b);
    sum_t s;
    s = sum_t'(a) + sum_t'(b);
    if (s >= sum_t'(NUM_CH)) s = s - sum_t'(NUM_CH);
    return s[CH_W-1:0];
  endfunction

  logic [NUM_CH-1:0] rot;
  ch_t               rot_idx;

  // Rotate the request vector so channel ptr appears at bit 0.
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_CH; i++) rot[i] = req[wrap_add(ptr, i)];
  end

  // Lowest set bit of the rotated vector, mapped back to a channel index.
  always_comb begin
    rot_idx    = '0;
    gnt_any    = 1'b0;
    gnt_onehot = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        rot_idx = ch_t'(i);
        gnt_any = 1'b1;
      end
    end
    gnt_idx             = wrap_add(ptr, int'(rot_idx));
    gnt_onehot[gnt_idx] = gnt_any;
  end

endmodule

// File: rtl/logger_ev_arbiter.sv
// Round-robin merge of NUM_CH timestamper event streams into one
// registered event output tagged with its source channel.
module logger_ev_arbiter
  import logger_pkg::*;
#(
  parameter int  NUM_CH = 4,
  parameter int  TS_W   = TS_W_DEF,
  parameter int  ID_W   = ID_W_DEF,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      cfg_ch_en,
  input  logic [NUM_CH-1:0]      s_ev_valid,
  output logic [NUM_CH-1:0]      s_ev_ready,
  input  logic [NUM_CH*ID_W-1:0] s_ev_id,
  input  logic [NUM_CH*TS_W-1:0] s_ev_start,
  input  logic [NUM_CH*TS_W-1:0] s_ev_end,
  input  logic [NUM_CH*TS_W-1:0] s_ev_delta,
  output logic                   m_ev_valid,
  input  logic                   m_ev_ready,
  output logic [ID_W-1:0]        m_ev_id,
  output logic [TS_W-1:0]        m_ev_start,
  output logic [TS_W-1:0]        m_ev_end,
  output logic [TS_W-1:0]        m_ev_delta,
  output logic [CH_W-1:0]        m_ev_ch,
  output logic [31:0]            accept_cnt
);

  typedef logic [CH_W-1:0] ch_t;

  arb_state_t        state_q, state_d;
  ch_t               rr_ptr_q, rr_ptr_d;
  ch_t               ch_q, ch_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [TS_W-1:0]   start_q, start_d;
  logic [TS_W-1:0]   end_q, end_d;
  logic [TS_W-1:0]   delta_q, delta_d;
  logic [31:0]       cnt_q, cnt_d;

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] gnt_onehot;
  ch_t               gnt_idx;
  logic              gnt_any;

  assign req = s_ev_valid & cfg_ch_en;

  logger_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req        (req),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  // Grant and capture while EMPTY; hold until the packer takes the event while FULL.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    ch_d       = ch_q;
    id_d       = id_q;
    start_d    = start_q;
    end_d      = end_q;
    delta_d    = delta_q;
    cnt_d      = cnt_q;
    s_ev_ready = '0;
    unique case (state_q)
      EMPTY: begin
        // No handshakes are offered while reset is asserted.
        if (!rst) s_ev_ready = gnt_onehot;
        if (gnt_any) begin
          ch_d     = gnt_idx;
          id_d     = s_ev_id[gnt_idx*ID_W +: ID_W];
          start_d  = s_ev_start[gnt_idx*TS_W +: TS_W];
          end_d    = s_ev_end[gnt_idx*TS_W +: TS_W];
          delta_d  = s_ev_delta[gnt_idx*TS_W +: TS_W];
          rr_ptr_d = (gnt_idx == ch_t'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
          cnt_d    = cnt_q + 32'd1;
          state_d  = FULL;
        end
      end
      FULL: begin
        if (m_ev_ready) state_d = EMPTY;
      end
    endcase
  end

  // State, pointer, counter and held-event registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
      ch_q     <= '0;
      id_q     <= '0;
      start_q  <= '0;
      end_q    <= '0;
      delta_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      ch_q     <= ch_d;
      id_q     <= id_d;
      start_q  <= start_d;
      end_q    <= end_d;
      delta_q  <= delta_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m_ev_valid = (state_q == FULL);
  assign m_ev_ch    = ch_q;
  assign m_ev_id    = id_q;
  assign m_ev_start = start_q;
  assign m_ev_end   = end_q;
  assign m_ev_delta = delta_q;
  assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_logger_ev_arbiter.sv
// Bench for logger_ev_arbiter: a 4-channel instance checked by a scoreboard
// monitor plus scenario tasks, and a 3-channel instance for wrap and mid-reset.
module tb_logger_ev_arbiter;

  localparam int N4 = 4;
  localparam int N3 = 3;
  localparam int TW = 64;
  localparam int IW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 4-channel instance signals
  logic [N4-1:0]    en4, v4, rdy4;
  logic [IW-1:0]    id4 [N4];
  logic [TW-1:0]    st4 [N4];
  logic [TW-1:0]    ed4 [N4];
  logic [TW-1:0]    dl4 [N4];
  logic [N4*IW-1:0] id4_bus;
  logic [N4*TW-1:0] st4_bus, ed4_bus, dl4_bus;
  logic             m_v4, m_r4;
  logic [IW-1:0]    m_id4;
  logic [TW-1:0]    m_st4, m_ed4, m_dl4;
  logic [1:0]       m_ch4;
  logic [31:0]      cnt4;

  // 3-channel instance signals
  logic [N3-1:0]    en3, v3, rdy3;
  logic [N3*IW-1:0] id3_bus;
  logic [N3*TW-1:0] st3_bus, ed3_bus, dl3_bus;
  logic             m_v3, m_r3;
  logic [IW-1:0]    m_id3;
  logic [TW-1:0]    m_st3, m_ed3, m_dl3;
  logic [1:0]       m_ch3;
  logic [31:0]      cnt3;

  always_comb begin
    id4_bus = '0;
    st4_bus = '0;
    ed4_bus = '0;
    dl4_bus = '0;
    for (int i = 0; i < N4; i++) begin
      id4_bus[i*IW +: IW] = id4[i];
      st4_bus[i*TW +: TW] = st4[i];
      ed4_bus[i*TW +: TW] = ed4[i];
      dl4_bus[i*TW +: TW] = dl4[i];
    end
  end

  logger_ev_arbiter #(.NUM_CH(N4), .TS_W(TW), .ID_W(IW)) dut4 (
    .clk(clk), .rst(rst), .cfg_ch_en(en4), .s_ev_valid(v4), .s_ev_ready(rdy4),
    .s_ev_id(id4_bus), .s_ev_start(st4_bus), .s_ev_end(ed4_bus), .s_ev_delta(dl4_bus),
    .m_ev_valid(m_v4), .m_ev_ready(m_r4), .m_ev_id(m_id4), .m_ev_start(m_st4),
    .m_ev_end(m_ed4), .m_ev_delta(m_dl4), .m_ev_ch(m_ch4), .accept_cnt(cnt4)
  );

  logger_ev_arbiter #(.NUM_CH(N3), .TS_W(TW), .ID_W(IW)) dut3 (
    .clk(clk), .rst(rst), .cfg_ch_en(en3), .s_ev_valid(v3), .s_ev_ready(rdy3),
    .s_ev_id(id3_bus), .s_ev_start(st3_bus), .s_ev_end(ed3_bus), .s_ev_delta(dl3_bus),
    .m_ev_valid(m_v3), .m_ev_ready(m_r3), .m_ev_id(m_id3), .m_ev_start(m_st3),
    .m_ev_end(m_ed3), .m_ev_delta(m_dl3), .m_ev_ch(m_ch3), .accept_cnt(cnt3)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0]    ch;
    logic [IW-1:0] id;
    logic [TW-1:0] st;
    logic [TW-1:0] ed;
    logic [TW-1:0] dl;
  } exp_t;

  exp_t        sb[$];
  int          ch_log[$];
  bit          mdl_full = 1'b0;
  int          mdl_ptr  = 0;
  logic [31:0] mdl_cnt  = '0;

  // Reference round-robin: walk ptr, ptr+1, ... modulo n.
  function automatic int rr_model(input logic [N4-1:0] req, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      int c;
      c = (ptr + k) % n;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // Scoreboard monitor for the 4-channel instance, sampled on the falling edge.
  always @(negedge clk) begin
    logic [N4-1:0] exp_rdy;
    int            g;
    exp_t          e;
    exp_rdy = '0;
    g = -1;
    if (!rst && !mdl_full) begin
      g = rr_model(v4 & en4, mdl_ptr, N4);
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    n_cmp++;
    if (rdy4 !== exp_rdy) begin
      n_err++;
      $display("FAIL sb_ready t=%0t: got %b want %b", $time, rdy4, exp_rdy);
    end
    n_cmp++;
    if (m_v4 !== mdl_full) begin
      n_err++;
      $display("FAIL sb_valid t=%0t: got %b want %b", $time, m_v4, mdl_full);
    end
    n_cmp++;
    if (cnt4 !== mdl_cnt) begin
      n_err++;
      $display("FAIL sb_count t=%0t: got %0d want %0d", $time, cnt4, mdl_cnt);
    end
    if (rst) begin
      mdl_full = 1'b0;
      mdl_ptr  = 0;
      mdl_cnt  = '0;
      sb.delete();
    end else if (g >= 0) begin
      e.ch = 2'(g);
      e.id = id4[g];
      e.st = st4[g];
      e.ed = ed4[g];
      e.dl = dl4[g];
      sb.push_back(e);
      mdl_full = 1'b1;
      mdl_ptr  = (g + 1) % N4;
      mdl_cnt  = mdl_cnt + 32'd1;
    end else if (mdl_full && m_r4) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_empty t=%0t: got handshake want none queued", $time);
      end else begin
        e = sb.pop_front();
        if ({m_ch4, m_id4, m_st4, m_ed4, m_dl4} !== e) begin
          n_err++;
          $display("FAIL sb_data t=%0t: got ch=%0d id=%h st=%h ed=%h dl=%h want ch=%0d id=%h st=%h ed=%h dl=%h",
                   $time, m_ch4, m_id4, m_st4, m_ed4, m_dl4, e.ch, e.id, e.st, e.ed, e.dl);
        end
      end
      ch_log.push_back(int'(m_ch4));
      mdl_full = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_data4(input logic [15:0] base);
    for (int i = 0; i < N4; i++) begin
      id4[i] = base + 16'(i);
      st4[i] = {48'h0, base} + 64'(i * 16'h10 + 1);
      ed4[i] = {48'h0, base} + 64'(i * 16'h10 + 2);
      dl4[i] = {48'h0, base} + 64'(i * 16'h10 + 3);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rdy4 !== 4'b0000 || rdy3 !== 3'b000) begin
        n_err++;
        $display("FAIL reset_ready: got %b/%b want 0000/000", rdy4, rdy3);
      end
      n_cmp++;
      if (m_v4 !== 1'b0 || m_v3 !== 1'b0) begin
        n_err++;
        $display("FAIL reset_valid: got %b/%b want 0/0", m_v4, m_v3);
      end
      n_cmp++;
      if (cnt4 !== 32'd0 || m_ch4 !== 2'd0 || m_id4 !== 16'd0) begin
        n_err++;
        $display("FAIL reset_regs: got cnt=%0d ch=%0d id=%h want 0 0 0", cnt4, m_ch4, m_id4);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    v4  = '0;
    v3  = '0;
  endtask

  task automatic test_single();
    set_data4(16'h0500);
    id4[1] = 16'h12AB;
    st4[1] = 64'h10;
    ed4[1] = 64'h30;
    dl4[1] = 64'h20;
    v4   = 4'b0010;
    m_r4 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rdy4 !== 4'b0010) begin
      n_err++;
      $display("FAIL single_ready: got %b want 0010", rdy4);
    end
    tick();
    v4 = '0;
    @(negedge clk);
    n_cmp++;
    if (m_v4 !== 1'b1 || m_ch4 !== 2'd1) begin
      n_err++;
      $display("FAIL single_out: got valid=%b ch=%0d want 1 1", m_v4, m_ch4);
    end
    n_cmp++;
    if (m_id4 !== 16'h12AB || m_st4 !== 64'h10 || m_ed4 !== 64'h30 || m_dl4 !== 64'h20) begin
      n_err++;
      $display("FAIL single_data: got %h %h %h %h want 12ab 10 30 20", m_id4, m_st4, m_ed4, m_dl4);
    end
    n_cmp++;
    if (cnt4 !== 32'd1) begin
      n_err++;
      $display("FAIL single_count: got %0d want 1", cnt4);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (m_v4 !== 1'b0) begin
      n_err++;
      $display("FAIL single_drop: got valid=%b want 0", m_v4);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int  exp_seq[6];
    bit  prev_v;
    int  pulses;
    exp_seq = '{0, 1, 2, 3, 0, 1};
    do_reset();
    ch_log.delete();
    set_data4(16'h2000);
    v4 = 4'b1111;
    m_r4 = 1'b1;
    prev_v = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (m_v4 === 1'b1) pulses++;
      n_cmp++;
      if (prev_v && m_v4 === 1'b1) begin
        n_err++;
        $display("FAIL rr_bubble cycle %0d: got back-to-back valid want idle between", c);
      end
      prev_v = (m_v4 === 1'b1);
    end
    tick();
    v4 = '0;
    n_cmp++;
    if (pulses != 6) begin
      n_err++;
      $display("FAIL rr_pulses: got %0d want 6", pulses);
    end
    n_cmp++;
    if (ch_log.size() != 6) begin
      n_err++;
      $display("FAIL rr_len: got %0d want 6", ch_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (ch_log[i] != exp_seq[i]) begin
          n_err++;
          $display("FAIL rr_seq[%0d]: got %0d want %0d", i, ch_log[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ch_log.delete();
    set_data4(16'hB000);
    v4   = 4'b1111;
    m_r4 = 1'b0;
    @(negedge clk);
    tick();
    set_data4(16'h7700);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (m_v4 !== 1'b1 || m_ch4 !== 2'd0 || m_id4 !== 16'hB000 || m_st4 !== 64'hB001 ||
          m_ed4 !== 64'hB002 || m_dl4 !== 64'hB003) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d: got v=%b ch=%0d id=%h st=%h want 1 0 b000 b001",
                 c, m_v4, m_ch4, m_id4, m_st4);
      end
      n_cmp++;
      if (rdy4 !== 4'b0000) begin
        n_err++;
        $display("FAIL bp_ready cycle %0d: got %b want 0000", c, rdy4);
      end
    end
    tick();
    m_r4 = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_cmp++;
    if (rdy4 !== 4'b0010) begin
      n_err++;
      $display("FAIL bp_next_grant: got %b want 0010", rdy4);
    end
    tick();
    v4 = '0;
    @(negedge clk);
    tick();
    n_cmp++;
    if (ch_log.size() != 2 || ch_log[0] != 0 || ch_log[1] != 1) begin
      n_err++;
      $display("FAIL bp_seq: got %p want '{0, 1}", ch_log);
    end
  endtask

  task automatic test_mask();
    int exp_seq[4];
    exp_seq = '{0, 1, 3, 0};
    do_reset();
    ch_log.delete();
    set_data4(16'h4400);
    en4  = 4'b1011;
    v4   = 4'b1111;
    m_r4 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rdy4[2] !== 1'b0) begin
        n_err++;
        $display("FAIL mask_ready cycle %0d: got %b want bit2=0", c, rdy4);
      end
    end
    tick();
    v4  = '0;
    en4 = 4'b1111;
    n_cmp++;
    if (ch_log.size() != 4) begin
      n_err++;
      $display("FAIL mask_len: got %0d want 4", ch_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (ch_log[i] != exp_seq[i]) begin
          n_err++;
          $display("FAIL mask_seq[%0d]: got %0d want %0d", i, ch_log[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_wrap_reset();
    int log3[$];
    int exp_seq[4];
    exp_seq = '{0, 1, 2, 0};
    do_reset();
    v3   = 3'b111;
    m_r3 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_v3 === 1'b1 && m_r3 === 1'b1) log3.push_back(int'(m_ch3));
    end
    tick();
    m_r3 = 1'b0;
    n_cmp++;
    if (log3.size() != 4) begin
      n_err++;
      $display("FAIL wrap_len: got %0d want 4", log3.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (log3[i] != exp_seq[i]) begin
          n_err++;
          $display("FAIL wrap_seq[%0d]: got %0d want %0d", i, log3[i], exp_seq[i]);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (rdy3 !== 3'b010) begin
      n_err++;
      $display("FAIL wrap_grant1: got %b want 010", rdy3);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (m_v3 !== 1'b1 || m_ch3 !== 2'd1 || m_id3 !== 16'hC001 || cnt3 !== 32'd5) begin
      n_err++;
      $display("FAIL wrap_full: got v=%b ch=%0d id=%h cnt=%0d want 1 1 c001 5", m_v3, m_ch3, m_id3, cnt3);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_v3 !== 1'b0 || m_ch3 !== 2'd0 || m_id3 !== 16'd0 || m_st3 !== 64'd0 || cnt3 !== 32'd0) begin
      n_err++;
      $display("FAIL wrap_midreset: got v=%b ch=%0d id=%h st=%h cnt=%0d want 0 0 0 0 0",
               m_v3, m_ch3, m_id3, m_st3, cnt3);
    end
    n_cmp++;
    if (rdy3 !== 3'b001) begin
      n_err++;
      $display("FAIL wrap_first_grant: got %b want 001", rdy3);
    end
    tick();
    v3 = '0;
    m_r3 = 1'b1;
    tick();
  endtask

  initial begin
    rst  = 1'b1;
    en4  = 4'b1111;
    v4   = 4'b1111;
    m_r4 = 1'b1;
    set_data4(16'h0100);
    en3  = 3'b111;
    v3   = 3'b111;
    m_r3 = 1'b1;
    id3_bus = {16'hC002, 16'hC001, 16'hC000};
    st3_bus = {64'h302, 64'h301, 64'h300};
    ed3_bus = {64'h402, 64'h401, 64'h400};
    dl3_bus = {64'h502, 64'h501, 64'h500};

    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_wrap_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
